hdmi_tx_cfg_sequencer: RTL and testbench

- Sequences the ADV7513 HDMI transmitter register initialisation.
- Walks an external register table (reg address, value pairs) and issues one single-byte write per entry to a downstream I2C byte-write master over a req/response handshake.
- Waits a power-up delay first, retries NACKed writes, and re-runs the full table on each hot-plug interrupt (HDMI_TX_INT).
- Sits between the PLL-lock/reset logic and the I2C master in the HDMI TX subsystem.

---
 rtl/hdmi_tx_cfg_sequencer.sv | 129 ++++++++++++
 tb/tb_hdmi_tx_cfg_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_cfg_sequencer.sv
// hdmi_tx_cfg_sequencer: walks the ADV7513 register table, issuing one I2C byte write per entry with power-up delay, NACK retry and hot-plug rerun
module hdmi_tx_cfg_sequencer #(
    parameter int         TBL_LEN     = 31,
    parameter logic [7:0] DEV_ADDR    = 8'h72,
    parameter int         PWRUP_DELAY = 1000000,
    parameter int         MAX_RETRY   = 3,
    parameter int         RETRY_GAP   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hdmi_tx_int,
    output logic [5:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_ack,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        config_done,
    output logic        error,
    output logic [7:0]  write_count
);
    localparam int CW = $clog2((PWRUP_DELAY > RETRY_GAP ? PWRUP_DELAY : RETRY_GAP) + 1);
    typedef enum logic [2:0] {S_IDLE, S_PWRUP, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_index;
    logic [7:0]    r_retry, r_reg, r_wdata, r_dev, r_wcnt;
    logic          r_req, r_busy, r_done, r_err, r_pend;
    logic          r_s1, r_s2, r_s3, r_edge;
    logic          w_resp, w_last, w_acked, w_nack_retry, w_restart;
    assign tbl_addr     = r_index;
    assign i2c_req      = r_req;
    assign i2c_dev_addr = r_dev;
    assign i2c_reg      = r_reg;
    assign i2c_wdata    = r_wdata;
    assign busy         = r_busy;
    assign config_done  = r_done;
    assign error        = r_err;
    assign write_count  = r_wcnt;
    assign w_resp       = i2c_ack | i2c_nack;
    assign w_last       = r_index == 6'(TBL_LEN - 1);
    assign w_acked      = r_state == S_WAIT && i2c_ack && !i2c_nack;
    assign w_nack_retry = r_state == S_WAIT && w_next == S_GAP;
    assign w_restart    = (r_state == S_DONE || r_state == S_ERR) && w_next == S_FETCH;
    // two-flop synchroniser plus a registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_s1   <= hdmi_tx_int;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_edge <= r_s2 & ~r_s3;
        end
    end
    always_ff @(posedge clk) begin
        r_state <= reset ? S_IDLE : w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_PWRUP : S_IDLE;
            S_PWRUP: w_next = !start ? S_IDLE : (r_cnt == '0) ? S_FETCH : S_PWRUP;
            S_FETCH: w_next = !start ? S_IDLE : S_ISSUE;
            S_ISSUE: w_next = !start ? S_IDLE : (tbl_data[15:8] == 8'hFF) ? S_DONE : S_WAIT;
            S_WAIT:  w_next = !w_resp ? S_WAIT : !start ? S_IDLE :
                              i2c_nack ? ((r_retry < 8'(MAX_RETRY)) ? S_GAP : S_ERR) :
                              w_last ? S_DONE : S_FETCH;
            S_GAP:   w_next = !start ? S_IDLE : (r_cnt == '0) ? S_FETCH : S_GAP;
            S_DONE:  w_next = !start ? S_IDLE : (r_edge || r_pend) ? S_FETCH : S_DONE;
            S_ERR:   w_next = !start ? S_IDLE : r_edge ? S_FETCH : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end
    // entering IDLE wipes every output, so an abort looks exactly like reset
    always_ff @(posedge clk) begin
        if (reset || w_next == S_IDLE) begin
            r_cnt   <= CW'(PWRUP_DELAY - 1);
            r_index <= '0;
            r_retry <= '0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_dev   <= '0;
            r_wcnt  <= '0;
            r_pend  <= 1'b0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_req  <= w_next == S_WAIT;
            r_busy <= w_next inside {S_PWRUP, S_FETCH, S_ISSUE, S_WAIT, S_GAP};
            r_done <= w_next == S_DONE;
            r_err  <= w_next == S_ERR;
            if (w_nack_retry)
                r_cnt <= CW'(RETRY_GAP - 1);
            else if (r_state == S_PWRUP || r_state == S_GAP)
                r_cnt <= r_cnt - 1'b1;
            if (r_state == S_ISSUE) begin
                r_reg   <= tbl_data[15:8];
                r_wdata <= tbl_data[7:0];
                r_dev   <= DEV_ADDR;
            end
            if (w_restart) begin
                r_index <= '0;
                r_wcnt  <= '0;
                r_retry <= '0;
                r_pend  <= 1'b0;
            end else begin
                if (r_edge && r_busy)
                    r_pend <= 1'b1;
                if (w_acked) begin
                    r_wcnt  <= (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;
                    r_retry <= '0;
                    if (!w_last)
                        r_index <= r_index + 6'd1;
                end else if (w_nack_retry)
                    r_retry <= r_retry + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_tx_cfg_sequencer.sv
// tb_hdmi_tx_cfg_sequencer: directed and randomized table walks checked against a per-entry write model
module tb_hdmi_tx_cfg_sequencer;
    localparam int         TBL_LEN     = 3;
    localparam int         PWRUP_DELAY = 4;
    localparam int         MAX_RETRY   = 3;
    localparam int         RETRY_GAP   = 16;
    localparam logic [7:0] DEV         = 8'h72;
    logic        clk = 0, reset = 1, start = 0, hdmi_tx_int = 0, i2c_ack = 0, i2c_nack = 0;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        i2c_req, busy, config_done, error;
    logic [7:0]  i2c_dev_addr, i2c_reg, i2c_wdata, write_count;
    logic [15:0] tbl [64];
    int          nacks [TBL_LEN];
    typedef struct {logic [7:0] r; logic [7:0] d; bit nk; int idx;} tr_t;
    tr_t         exp_q [$];
    int          exp_wc;
    bit          exp_err;
    int          n_vec = 0, n_mis = 0;

    hdmi_tx_cfg_sequencer #(.TBL_LEN(TBL_LEN), .DEV_ADDR(DEV), .PWRUP_DELAY(PWRUP_DELAY),
                            .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .hdmi_tx_int(hdmi_tx_int),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .i2c_req(i2c_req),
        .i2c_dev_addr(i2c_dev_addr), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_ack(i2c_ack), .i2c_nack(i2c_nack), .busy(busy), .config_done(config_done),
        .error(error), .write_count(write_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({i2c_req, busy, config_done, error, tbl_addr}), 0);
        check({tag, "_dat"}, {write_count, i2c_reg, i2c_wdata, i2c_dev_addr}, 0);
    endtask

    // expected write sequence: each entry until FF or the end, repeated once per NACK, abandoned past the retry limit
    task automatic model_pass();
        exp_q.delete();
        exp_wc  = 0;
        exp_err = 0;
        for (int i = 0; i < TBL_LEN; i++) begin
            if (tbl[i][15:8] == 8'hFF) break;
            for (int a = 0; a <= nacks[i] && a <= MAX_RETRY; a++)
                exp_q.push_back('{r: tbl[i][15:8], d: tbl[i][7:0], nk: a < nacks[i], idx: i});
            if (nacks[i] > MAX_RETRY) begin
                exp_err = 1;
                break;
            end
            exp_wc++;
        end
    endtask

    task automatic respond(input bit nk, input int dly, input bit hp, output logic [7:0] r, output logic [7:0] d,
                           output logic [7:0] dv, output logic [5:0] a, output int w);
        w = 0;
        while (!i2c_req && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("req_seen", 32'(i2c_req), 1);
        r  = i2c_reg;
        d  = i2c_wdata;
        dv = i2c_dev_addr;
        a  = tbl_addr;
        if (hp) hdmi_tx_int = 1;
        for (int j = 0; j < dly; j++) begin
            @(negedge clk);
            check("hold", 32'({i2c_req, i2c_reg, i2c_wdata}), 32'({1'b1, r, d}));
        end
        if (nk) begin
            i2c_nack = 1;
            i2c_ack  = 1'($urandom_range(0, 1));
        end else
            i2c_ack = 1;
        @(negedge clk);
        i2c_ack  = 0;
        i2c_nack = 0;
        check("req_drop", 32'(i2c_req), 0);
    endtask

    task automatic run_pass(input int first_wait, input int hp_at);
        logic [7:0] r, d, dv;
        logic [5:0] a;
        int w, n;
        bit prev_nk = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            respond(exp_q[k].nk, $urandom_range(0, 5), hp_at == k, r, d, dv, a, w);
            check("reg", 32'(r), 32'(exp_q[k].r));
            check("wdata", 32'(d), 32'(exp_q[k].d));
            check("dev", 32'(dv), 32'(DEV));
            check("addr", 32'(a), exp_q[k].idx);
            if (k == 0) check("lat_first", w, first_wait);
            else check("lat_next", w, prev_nk ? RETRY_GAP + 2 : 2);
            prev_nk = exp_q[k].nk;
        end
        n = 0;
        while (!(config_done || error) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("end_seen", 32'(n < 40), 1);
        check("done", 32'(config_done), 32'(!exp_err));
        check("error", 32'(error), 32'(exp_err));
        check("busy_end", 32'(busy), 0);
        check("wcount", 32'(write_count), exp_wc);
    endtask

    task automatic quiet(input int n, input string tag);
        bit saw = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            saw |= i2c_req;
        end
        check({tag, "_noreq"}, 32'(saw), 0);
        check({tag, "_done"}, 32'(config_done), 32'(!exp_err));
        check({tag, "_err"}, 32'(error), 32'(exp_err));
    endtask

    task automatic go_idle();
        start       = 0;
        hdmi_tx_int = 0;
        repeat (4) @(negedge clk);
        check("idle", 32'({busy, config_done, error, i2c_req}), 0);
    endtask

    // edge after DONE/ERR: restart straight into FETCH at index 0, no power-up wait
    task automatic hot_plug();
        hdmi_tx_int = 0;
        repeat (4) @(negedge clk);
        hdmi_tx_int = 1;
        repeat (3) @(negedge clk);
        check("hp_before", 32'(config_done | error), 1);
        @(negedge clk);
        check("hp_done", 32'(config_done), 0);
        check("hp_err", 32'(error), 0);
        check("hp_busy", 32'(busy), 1);
        check("hp_wc", 32'(write_count), 0);
        check("hp_addr", 32'(tbl_addr), 0);
    endtask

    task automatic set_nacks(input int n0, input int n1, input int n2);
        nacks[0] = n0;
        nacks[1] = n1;
        nacks[2] = n2;
    endtask

    initial begin
        int w;
        for (int i = 0; i < 64; i++) tbl[i] = 16'h0000;
        tbl[0] = 16'h4110;
        tbl[1] = 16'h9803;
        tbl[2] = 16'hD6C0;
        set_nacks(0, 0, 0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 0;
        @(negedge clk);
        check_zero("idle0");

        model_pass();
        start = 1;
        run_pass(PWRUP_DELAY + 3, -1);
        quiet(10, "nominal");

        hot_plug();
        run_pass(2, -1);
        quiet(10, "hp_after");

        go_idle();
        start = 1;
        run_pass(PWRUP_DELAY + 3, 1);
        @(negedge clk);
        check("hp_mid_done", 32'(config_done), 0);
        check("hp_mid_busy", 32'(busy), 1);
        check("hp_mid_wc", 32'(write_count), 0);
        run_pass(2, -1);
        quiet(10, "hp_mid");

        go_idle();
        set_nacks(0, 2, 0);
        model_pass();
        start = 1;
        run_pass(PWRUP_DELAY + 3, -1);
        quiet(10, "nack");

        go_idle();
        set_nacks(MAX_RETRY + 1, 0, 0);
        model_pass();
        start = 1;
        run_pass(PWRUP_DELAY + 3, -1);
        check("exhaust_reqs", exp_q.size(), 4);
        quiet(30, "exhaust");
        set_nacks(0, 0, 0);
        model_pass();
        hot_plug();
        run_pass(2, -1);

        go_idle();
        tbl[1] = 16'hFF00;
        model_pass();
        start = 1;
        run_pass(PWRUP_DELAY + 3, -1);
        check("early_wc", exp_wc, 1);
        quiet(10, "early");
        tbl[1] = 16'h9803;

        go_idle();
        start = 1;
        w = 0;
        while (!i2c_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("abort_req", 32'(i2c_req), 1);
        start = 0;
        repeat (3) @(negedge clk);
        check("abort_hold", 32'(i2c_req), 1);
        i2c_ack = 1;
        @(negedge clk);
        i2c_ack = 0;
        check_zero("abort");
        @(negedge clk);
        check_zero("abort_idle");

        start = 1;
        w = 0;
        while (!i2c_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_req", 32'(i2c_req), 1);
        reset = 1;
        @(negedge clk);
        check_zero("rst_mid");
        start = 0;
        @(negedge clk);
        reset = 0;

        for (int it = 0; it < 8; it++) begin
            go_idle();
            for (int i = 0; i < TBL_LEN; i++) begin
                tbl[i]   = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
                nacks[i] = ($urandom_range(0, 5) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, MAX_RETRY));
            end
            if ($urandom_range(0, 3) == 0)
                tbl[$urandom_range(1, TBL_LEN - 1)] = 16'hFF00 | 16'($urandom_range(0, 255));
            model_pass();
            start = 1;
            run_pass(PWRUP_DELAY + 3, -1);
            quiet(25, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
